// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//
// Contents:
//   UART_BYTE_W     width of one transmitted byte
//   TX_ARB_TIMEOUT  default watchdog limit (clocks) for uart_tx_arb
//   tx_arb_state_t  uart_tx_arb FSM states (IDLE, LAUNCH, WAIT_DONE)
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int TX_ARB_TIMEOUT = 200000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//
// The search begins at index (i_ptr + 1) mod N and returns the first
// requesting index as a one-hot grant.
//
// Ports:
//   i_req    [N-1:0]      request vector
//   i_ptr    [PTR_W-1:0]  last granted index
//   o_grant  [N-1:0]      one-hot winner (0 when nothing requests)
//   o_valid               at least one request present
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic             o_valid
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shr;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;
  logic [PTR_W:0] sh;

  // Rotate the requests so the first index to search lands on bit 0, take
  // the lowest set bit, then rotate the one-hot result back. sh is one bit
  // wider than the pointer so that ptr = N-1 yields a shift of N (identity)
  // even when N is a power of two.
  always_comb begin
    sh      = {1'b0, i_ptr} + {{PTR_W{1'b0}}, 1'b1};
    req_dbl = {i_req, i_req};
    req_shr = req_dbl >> sh;
    rot_req = req_shr[N-1:0];
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt_dbl = {{N{1'b0}}, rot_gnt} << sh;
    o_grant = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
    o_valid = |i_req;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte sources. Exactly one byte is in flight at a time, and a
// packet lock keeps a requester's multi-byte message contiguous.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a watchdog that
// aborts a stuck byte or a stalled lock after TIMEOUT_CYCLES clocks.
//
// Handshake: a requester raises i_req[k] with i_req_byte/i_req_last stable
// and holds it until o_req_ack[k] pulses for one cycle; the ack pulse is the
// only point at which the byte is consumed, so dropping i_req before the
// ack simply withdraws the byte. Toward the UART, o_tx_byte_rdy is a
// one-cycle launch with o_tx_byte valid, and i_tx_done closes the byte.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            per-requester byte valid
//   i_req_byte       byte of requester k at [8k+7:8k]
//   i_req_last       byte ends its packet
//   o_req_ack        one-cycle consume pulse to the granted requester
//   o_tx_byte_rdy    one-cycle launch pulse to the UART
//   o_tx_byte        registered byte to the UART
//   i_tx_busy        UART busy; holds off arbitration in IDLE
//   i_tx_done        UART stop-bit-end pulse
//   o_grant          one-hot owner of the current byte or locked packet
//   o_busy           FSM not idle, or packet lock held
//   o_timeout        watchdog abort pulse (0 without the watchdog)
//   o_dbg_state      current FSM state
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = TX_ARB_TIMEOUT
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ack,
  output logic                           o_tx_byte_rdy,
  output logic [UART_BYTE_W-1:0]         o_tx_byte,
  input  logic                           i_tx_busy,
  input  logic                           i_tx_done,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic                           o_timeout,
  output tx_arb_state_t                  o_dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  tx_arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   rdy_q, rdy_d;
  logic [UART_BYTE_W-1:0] byte_q, byte_d;
  logic                   last_q, last_d;
  logic                   lock_q, lock_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     arb_grant;
  logic                   arb_valid;
  logic [UART_BYTE_W-1:0] win_byte;
  logic                   win_last;
  logic [PTR_W-1:0]       owner_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        wd_run;
`endif

  // While a packet is locked only its owner may win.
  assign eligible = lock_q ? (i_req & grant_q) : i_req;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (eligible),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_valid (arb_valid)
  );

  // Mux the winner's byte/last flag and encode the current owner's index.
  always_comb begin
    win_byte  = '0;
    win_last  = 1'b0;
    owner_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        win_byte = i_req_byte[k*UART_BYTE_W +: UART_BYTE_W];
        win_last = i_req_last[k];
      end
      if (grant_q[k]) begin
        owner_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    rdy_d     = 1'b0;
    byte_d    = byte_q;
    last_d    = last_q;
    lock_d    = lock_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Launch and ack are registered here so they appear in LAUNCH.
        if (!i_tx_busy && arb_valid) begin
          grant_d = arb_grant;
          byte_d  = win_byte;
          last_d  = win_last;
          ack_d   = arb_grant;
          rdy_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // A done arriving in this cycle belongs to no byte of ours.
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = IDLE;
          if (!last_q) begin
            lock_d = 1'b1;
          end else begin
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = owner_idx;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Counts while waiting on the UART, or while a locked owner has gone
    // quiet; any state change restarts it.
    wd_run = (state_q == WAIT_DONE) ||
             ((state_q == IDLE) && lock_q && !(|(i_req & grant_q)));
    wd_d   = '0;
    if ((state_d == state_q) && wd_run) begin
      if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        lock_d    = 1'b0;
        grant_d   = '0;
        ptr_d     = owner_idx;
        state_d   = IDLE;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      rdy_q     <= 1'b0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      lock_q    <= 1'b0;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      timeout_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      rdy_q     <= rdy_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign o_grant       = grant_q;
  assign o_req_ack     = ack_q;
  assign o_tx_byte_rdy = rdy_q;
  assign o_tx_byte     = byte_q;
  assign o_busy        = (state_q != IDLE) || lock_q;
  assign o_timeout     = timeout_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb. Requesters are byte queues; the expected
// launch order is derived packet-by-packet from the round-robin rule and
// compared against every launch observed on the UART side.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int NUM_REQ = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = TX_ARB_TIMEOUT;
`endif

  logic                   i_clk;
  logic                   i_rst_n;
  logic [NUM_REQ-1:0]     i_req;
  logic [8*NUM_REQ-1:0]   i_req_byte;
  logic [NUM_REQ-1:0]     i_req_last;
  logic [NUM_REQ-1:0]     o_req_ack;
  logic                   o_tx_byte_rdy;
  logic [7:0]             o_tx_byte;
  logic                   i_tx_busy;
  logic                   i_tx_done;
  logic [NUM_REQ-1:0]     o_grant;
  logic                   o_busy;
  logic                   o_timeout;
  tx_arb_state_t          dbg_state;

  int n_tests;
  int n_fail;

  uart_tx_arb #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_req_byte    (i_req_byte),
    .i_req_last    (i_req_last),
    .o_req_ack     (o_req_ack),
    .o_tx_byte_rdy (o_tx_byte_rdy),
    .o_tx_byte     (o_tx_byte),
    .i_tx_busy     (i_tx_busy),
    .i_tx_done     (i_tx_done),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- requester sources ----------------
  logic [8:0] src_mem [NUM_REQ][32];
  int         src_hd  [NUM_REQ];
  int         src_tl  [NUM_REQ];

  task automatic clear_src();
    for (int k = 0; k < NUM_REQ; k++) begin
      src_hd[k] = 0;
      src_tl[k] = 0;
    end
  endtask

  task automatic push_src(input int k, input logic [7:0] b, input logic l);
    src_mem[k][src_tl[k]] = {l, b};
    src_tl[k]++;
  endtask

  function automatic bit srcs_empty();
    for (int k = 0; k < NUM_REQ; k++)
      if (src_hd[k] < src_tl[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src_hd[k] < src_tl[k]) begin
        i_req[k]          = 1'b1;
        i_req_byte[8*k+:8] = src_mem[k][src_hd[k]][7:0];
        i_req_last[k]     = src_mem[k][src_hd[k]][8];
      end else begin
        i_req[k]          = 1'b0;
        i_req_byte[8*k+:8] = 8'h00;
        i_req_last[k]     = 1'b0;
      end
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // exp_q entries: {owner index[3:0], byte[7:0]}
  logic [11:0] exp_q[$];
  int          model_ptr;

  // Whole packets are served in turn; the next owner is the first source
  // holding data after the previous packet's owner.
  task automatic plan_expected();
    int   hd [NUM_REQ];
    int   found;
    int   k;
    logic last;
    for (int i = 0; i < NUM_REQ; i++) hd[i] = src_hd[i];
    for (int round = 0; round < 64; round++) begin
      found = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        k = (model_ptr + i) % NUM_REQ;
        if (found < 0 && hd[k] < src_tl[k]) found = k;
      end
      if (found < 0) break;
      do begin
        exp_q.push_back({4'(found), src_mem[found][hd[found]][7:0]});
        last = src_mem[found][hd[found]][8];
        hd[found]++;
      end while (!last && hd[found] < src_tl[found]);
      model_ptr = found;
    end
  endtask

  logic busy_seen;
  int   launches;
  int   timeouts;

  always @(posedge i_clk) busy_seen <= i_tx_busy;

  initial begin
    logic [11:0] e;
    logic [31:0] oh;
    launches = 0;
    timeouts = 0;
    forever begin
      @(negedge i_clk);
      if (o_tx_byte_rdy) begin
        launches++;
        if (exp_q.size() == 0) begin
          check("unplanned_launch", exp_q.size(), 1);
        end else begin
          e  = exp_q.pop_front();
          oh = 32'd1 << e[11:8];
          check("tx_byte", o_tx_byte, {24'd0, e[7:0]});
          check("launch_grant", o_grant, oh);
          check("launch_ack", o_req_ack, oh);
          check("busy_holdoff", busy_seen, 0);
        end
        for (int k = 0; k < NUM_REQ; k++)
          if (o_req_ack[k] && src_hd[k] < src_tl[k]) src_hd[k]++;
        drive_reqs();
      end else if (o_req_ack != '0) begin
        check("stray_ack", o_req_ack, 0);
      end
      if (o_timeout) timeouts++;
    end
  end

  // ---------------- UART model ----------------
  logic uart_busy, hold_busy, uart_mute, uart_active;
  int   fixed_delay, max_extra;

  assign i_tx_busy = uart_busy | hold_busy;

  initial begin
    int d;
    int x;
    uart_busy   = 1'b0;
    i_tx_done   = 1'b0;
    uart_active = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_byte_rdy && !uart_mute) begin
        uart_active = 1'b1;
        uart_busy   = 1'b1;
        d = (fixed_delay > 0) ? fixed_delay : $urandom_range(2, 12);
        x = $urandom_range(0, max_extra);
        repeat (d - 1) @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        repeat (x) @(negedge i_clk);
        uart_busy   = 1'b0;
        uart_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    clear_src();
    drive_reqs();
    exp_q.delete();
    model_ptr = NUM_REQ - 1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic wait_launch(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge i_clk);
      if (o_tx_byte_rdy) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && srcs_empty() && !o_busy && !uart_active && !o_tx_byte_rdy)
        break;
    end
    check({tag, "_drained"}, 32'(n < 4000), 1);
    check({tag, "_end_grant"}, o_grant, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int l0;
    int np;
    int len;
    n_tests     = 0;
    n_fail      = 0;
    i_rst_n     = 1'b0;
    hold_busy   = 1'b0;
    uart_mute   = 1'b0;
    fixed_delay = 0;
    max_extra   = 0;
    model_ptr   = NUM_REQ - 1;
    clear_src();
    drive_reqs();

    // Reset values
    repeat (3) @(negedge i_clk);
    check("rst_grant", o_grant, 0);
    check("rst_ack", o_req_ack, 0);
    check("rst_rdy", o_tx_byte_rdy, 0);
    check("rst_byte", o_tx_byte, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single request on index 1
    do_reset();
    fixed_delay = 10;
    push_src(1, 8'h41, 1'b1);
    plan_expected();
    drive_reqs();
    wait_launch(lat);
    check("single_latency", lat, 1);
    repeat (3) @(negedge i_clk);
    check("single_grant_hold", o_grant, 3'b010);
    check("single_busy", o_busy, 1);
    wait_idle("single");

    // Round-robin fairness: 0,1,2,0
    do_reset();
    fixed_delay = 10;
    push_src(0, 8'h10, 1'b1);
    push_src(0, 8'h13, 1'b1);
    push_src(1, 8'h11, 1'b1);
    push_src(2, 8'h12, 1'b1);
    plan_expected();
    l0 = launches;
    drive_reqs();
    wait_idle("fair");
    check("fair_launches", launches - l0, 4);

    // Packet lock: 0x48, 0x49 before requester 2
    do_reset();
    fixed_delay = 0;
    push_src(0, 8'h48, 1'b0);
    push_src(0, 8'h49, 1'b1);
    push_src(2, 8'h5A, 1'b1);
    plan_expected();
    drive_reqs();
    wait_idle("lock");

    // Busy hold-off
    do_reset();
    hold_busy = 1'b1;
    push_src(0, 8'h77, 1'b1);
    plan_expected();
    l0 = launches;
    drive_reqs();
    repeat (20) @(negedge i_clk);
    check("busy_no_launch", launches - l0, 0);
    check("busy_grant_idle", o_grant, 0);
    hold_busy = 1'b0;
    wait_launch(lat);
    check("busy_release_latency", lat, 1);
    wait_idle("busy");

    // Reset during WAIT_DONE with a lock held
    do_reset();
    fixed_delay = 30;
    push_src(0, 8'hA1, 1'b0);
    push_src(0, 8'hA2, 1'b0);
    push_src(0, 8'hA3, 1'b1);
    push_src(1, 8'hB1, 1'b1);
    plan_expected();
    l0 = launches;
    drive_reqs();
    for (int i = 0; i < 200 && (launches - l0) < 2; i++) @(negedge i_clk);
    check("rst_mid_two_launches", launches - l0, 2);
    repeat (3) @(negedge i_clk);
    check("rst_mid_locked_busy", o_busy, 1);
    check("rst_mid_locked_grant", o_grant, 3'b001);
    i_rst_n = 1'b0;
    clear_src();
    drive_reqs();
    exp_q.delete();
    model_ptr = NUM_REQ - 1;
    #1;
    check("rst_mid_grant", o_grant, 0);
    check("rst_mid_ack", o_req_ack, 0);
    check("rst_mid_rdy", o_tx_byte_rdy, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 100 && uart_active; i++) @(negedge i_clk);
    check("rst_mid_uart_quiet", uart_active, 0);
    check("rst_mid_unlocked", o_busy, 0);
    fixed_delay = 0;
    push_src(0, 8'hC0, 1'b1);
    push_src(1, 8'hC1, 1'b1);
    push_src(2, 8'hC2, 1'b1);
    plan_expected();
    drive_reqs();
    wait_idle("rst_mid");

    // Randomized packets, delays and trailing busy
    max_extra = 3;
    for (int r = 0; r < 10; r++) begin
      clear_src();
      for (int k = 0; k < NUM_REQ; k++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            push_src(k, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      plan_expected();
      drive_reqs();
      wait_idle("rand");
    end
    max_extra = 0;

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: no done ever returns
    do_reset();
    uart_mute = 1'b1;
    push_src(0, 8'h11, 1'b1);
    push_src(1, 8'h22, 1'b1);
    plan_expected();
    drive_reqs();
    wait_launch(lat);
    check("tmo_first_latency", lat, 1);
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge i_clk);
      if (o_timeout) begin
        lat = c;
        break;
      end
    end
    check("tmo_cycles", lat, TMO + 1);
    check("tmo_grant_cleared", o_grant, 0);
    @(negedge i_clk);
    check("tmo_next_launch", o_tx_byte_rdy, 1);
    check("tmo_next_grant", o_grant, 3'b010);
    repeat (TMO + 10) @(negedge i_clk);
    check("tmo_count", timeouts, 2);
    uart_mute = 1'b0;
    do_reset();
`else
    check("no_timeout_pulses", timeouts, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
